keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner_sync2.sv | 27 ++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd12;
    localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd14;

    // Bit 3 is line 0 on both the row and column buses.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterised width.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Double-register the raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_DWELL    = 8,
    parameter int SETTLE       = 2,
    parameter int DEBOUNCE     = 16,
    parameter int REPEAT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_err
);

    localparam int DW = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
    localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
    localparam logic [DW-1:0] SETTLE_C   = DW'(SETTLE);
    localparam logic [BW-1:0] PRESS_LAST = BW'(DEBOUNCE - 1);
    // The zero that moves PRESSED into DEB_REL is the first of the DEBOUNCE samples.
    localparam logic [BW-1:0] REL_LAST   = BW'(DEBOUNCE - 2);

    logic [3:0]    w_row_s;
    state_t        r_state;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_col;
    logic [3:0]    r_pattern;
    logic [BW-1:0] r_deb_cnt;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic          r_key_held;
    logic          r_multi_err;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] r_rep;
`endif

    sync2 #(.W(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_in),
        .o_q (w_row_s)
    );

    // Scan / debounce state machine and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SCAN;
            r_dwell     <= '0;
            r_col       <= 4'b1000;
            r_pattern   <= 4'b0000;
            r_deb_cnt   <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            r_multi_err <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if ((r_dwell >= SETTLE_C) && (w_row_s != 4'b0000)) begin
                        r_pattern <= w_row_s;
                        r_deb_cnt <= '0;
                        r_dwell   <= '0;
                        r_state   <= ST_DEB_PRESS;
                    end else if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        r_col   <= {r_col[0], r_col[3:1]};
                    end else begin
                        r_dwell <= r_dwell + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_row_s == 4'b0000) begin
                        r_dwell <= '0;
                        r_state <= ST_SCAN;
                    end else if (w_row_s != r_pattern) begin
                        r_pattern <= w_row_s;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == PRESS_LAST) begin
                        r_state <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        r_rep   <= '0;
`endif
                        if (is_onehot(r_pattern)) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= {onehot_to_idx(r_pattern), onehot_to_idx(r_col)};
                            r_key_held  <= 1'b1;
                        end else begin
                            r_multi_err <= 1'b1;
                            r_key_held  <= 1'b0;
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                ST_PRESSED: begin
                    if (w_row_s == 4'b0000) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_DEB_REL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (r_key_held) begin
                        if (r_rep == REP_LAST) begin
                            r_rep       <= '0;
                            r_key_valid <= 1'b1;
                        end else begin
                            r_rep <= r_rep + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end
`endif
                    else begin
                        r_state <= ST_PRESSED;
                    end
                end
                ST_DEB_REL: begin
                    if (w_row_s != 4'b0000) begin
                        r_state <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        r_rep   <= '0;
`endif
                    end else if (r_deb_cnt == REL_LAST) begin
                        r_key_held <= 1'b0;
                        r_dwell    <= '0;
                        r_col      <= {r_col[0], r_col[3:1]};
                        r_state    <= ST_SCAN;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign col_out   = r_col;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;
    assign multi_err = r_multi_err;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected key codes are queued at press time.
module tb_keypad_scanner;

    localparam int DEBOUNCE  = 16;
    localparam int COL_DWELL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_multi  = 0;
    logic [3:0] exp_q[$];

    keypad_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the cycle in which target has just become the driven column.
    task automatic wait_col(input logic [3:0] target, input string tag);
        logic [3:0] prev;
        bit ok;
        ok   = 1'b0;
        prev = col_out;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col_out == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = col_out;
        end
        check({tag, "_wait_col"}, {31'd0, ok}, 32'd1);
    endtask

    // Scoreboard: every strobe must match the oldest queued code.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                n_valid++;
                if (exp_q.size() == 0)
                    check("unexpected_strobe", {31'd0, key_valid}, 32'd0);
                else
                    check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
            if (multi_err) n_multi++;
        end
    end

    initial begin
        int base;
        int base_m;
        int lat;
        int rel;
        bit moved;

        rst    = 1'b1;
        row_in = 4'b0000;
        cycles(2);
        check("rst_col", {28'd0, col_out}, 32'h8);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_multi", {31'd0, multi_err}, 32'd0);
        rst = 1'b0;

        // Clean press R0 on C1, held 200 cycles.
        base = n_valid;
        wait_col(4'b0100, "clean");
        exp_q.push_back(4'd1);
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd1);
`endif
        row_in = 4'b1000;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid) begin
                lat = i;
                break;
            end
        end
        check("press_latency", lat, DEBOUNCE + 3);
        check("clean_held", {31'd0, key_held}, 32'd1);
        cycles(200 - lat);
        check("clean_frozen_col", {28'd0, col_out}, 32'h4);
`ifdef KEYPAD_REPEAT_EN
        check("clean_strobes", n_valid - base, 3);
`else
        check("clean_strobes", n_valid - base, 1);
`endif
        row_in = 4'b0000;
        rel = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (!key_held) begin
                rel = i;
                break;
            end
        end
        check("release_latency", rel, DEBOUNCE + 2);
        check("resume_col", {28'd0, col_out}, 32'h2);

        // Bounce, then stable R3 on C0.
        base = n_valid;
        wait_col(4'b1000, "bounce");
        for (int i = 0; i < 12; i++) begin
            row_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            cycles(5);
        end
        row_in = 4'b0000;
        cycles(3);
        check("bounce_no_early", n_valid - base, 0);
        wait_col(4'b1000, "bounce_c0");
        exp_q.push_back(4'd12);
        row_in = 4'b0001;
        cycles(DEBOUNCE + 6);
        check("bounce_strobes", n_valid - base, 1);
        check("bounce_held", {31'd0, key_held}, 32'd1);
        row_in = 4'b0000;
        cycles(DEBOUNCE + 6);
        check("bounce_released", {31'd0, key_held}, 32'd0);

        // Short glitch on C2.
        base = n_valid;
        wait_col(4'b0010, "glitch");
        row_in = 4'b0100;
        cycles(10);
        row_in = 4'b0000;
        moved = 1'b0;
        for (int i = 0; i < 4 * COL_DWELL; i++) begin
            @(negedge clk);
            if (col_out != 4'b0010) begin
                moved = 1'b1;
                break;
            end
        end
        check("glitch_rotation", {31'd0, moved}, 32'd1);
        check("glitch_no_strobe", n_valid - base, 0);

        // Two rows at once on C1.
        base   = n_valid;
        base_m = n_multi;
        wait_col(4'b0100, "multi");
        row_in = 4'b1010;
        cycles(40);
        check("multi_err_pulse", n_multi - base_m, 1);
        check("multi_no_strobe", n_valid - base, 0);
        check("multi_held", {31'd0, key_held}, 32'd0);
        check("multi_frozen_col", {28'd0, col_out}, 32'h4);
        row_in = 4'b0000;
        moved = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (col_out == 4'b0010) begin
                moved = 1'b1;
                break;
            end
        end
        check("multi_resume", {31'd0, moved}, 32'd1);

        // Reset in the middle of a press debounce on C3.
        base = n_valid;
        wait_col(4'b0001, "rstmid");
        row_in = 4'b0100;
        cycles(10);
        rst    = 1'b1;
        row_in = 4'b0000;
        cycles(1);
        check("rstmid_col", {28'd0, col_out}, 32'h8);
        check("rstmid_held", {31'd0, key_held}, 32'd0);
        check("rstmid_valid", {31'd0, key_valid}, 32'd0);
        rst = 1'b0;
        cycles(40);
        check("rstmid_no_strobe", n_valid - base, 0);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat on R3C2.
        base = n_valid;
        wait_col(4'b0010, "repeat");
        for (int i = 0; i < 5; i++) exp_q.push_back(4'd14);
        row_in = 4'b0001;
        cycles(DEBOUNCE + 3 + 300);
        row_in = 4'b0000;
        cycles(30);
        check("repeat_strobes", n_valid - base, 5);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
